imm_gen_pipe: RTL

- Pipelined, parametrised immediate generator for the RV decode stage.
- Successor to the 2-bit-mode 12/20-bit extender:
  - takes the full instruction word;
  - decodes all RV32I/RV64I immediate formats plus CSR zimm and zero-extended I-type;
  - drives a registered XLEN-wide result through a valid/ready handshake with a 2-entry skid buffer, so decode can stall without a combinational ready path.
- Sits between fetch/decode and the ALU operand mux.

---
 rtl/imm_gen_pipe.sv | 113 +++++++++++
 1 files changed

// File: rtl/imm_gen_pipe.sv
// Pipelined RV immediate generator. It decodes every immediate format from the raw
// instruction word and presents the result through a valid/ready handshake backed by a 2-entry skid buffer.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_fmt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    typedef enum logic [2:0] {
        FMT_I   = 3'b000,
        FMT_S   = 3'b001,
        FMT_B   = 3'b010,
        FMT_U   = 3'b011,
        FMT_J   = 3'b100,
        FMT_IU  = 3'b101,
        FMT_Z   = 3'b110,
        FMT_RSV = 3'b111
    } fmt_e;

    typedef struct packed {
        logic             valid;
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             err;
    } entry_t;

    entry_t      m_q;
    entry_t      s_q;
    entry_t      new_entry;
    logic [31:0] raw;
    logic        new_err;
    logic        accept;
    logic        pop;
    logic        unused_opcode;

    // The opcode field never contributes to an immediate.
    assign unused_opcode = ^in_instr[6:0];

    // raw always holds a 32-bit value whose bit 31 is the extension bit.
    // The zero-extended formats leave bit 31 clear, so one signed widen covers all of them.
    // NOTE: always_comb assigns every output first; otherwise a missing case arm infers a latch.
    always_comb begin
        raw     = '0;
        new_err = 1'b0;
        case (fmt_e'(in_fmt))
            FMT_I:   raw = {{20{in_instr[31]}}, in_instr[31:20]};
            FMT_S:   raw = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FMT_B:   raw = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                            in_instr[30:25], in_instr[11:8], 1'b0};
            FMT_U:   raw = {in_instr[31:12], 12'b0};
            FMT_J:   raw = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                            in_instr[20], in_instr[30:21], 1'b0};
            FMT_IU:  raw = {20'b0, in_instr[31:20]};
            FMT_Z:   raw = {27'b0, in_instr[19:15]};
            default: new_err = 1'b1;
        endcase
    end

    always_comb begin
        new_entry       = '0;
        new_entry.valid = 1'b1;
        new_entry.imm   = XLEN'($signed(raw));
        new_entry.tag   = in_tag;
        new_entry.err   = new_err;
    end

    // in_ready comes straight from the skid flop, so out_ready never reaches it combinationally.
    assign in_ready  = !s_q.valid;
    assign accept    = in_valid && in_ready;
    assign pop       = m_q.valid && out_ready;

    assign out_valid = m_q.valid;
    assign out_imm   = m_q.imm;
    assign out_tag   = m_q.tag;
    assign out_err   = m_q.err;

    // NOTE: the payload fields are reset along with the valid bits because the outputs must read zero after reset.
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q <= '0;
            s_q <= '0;
        end else if (pop && s_q.valid) begin
            m_q       <= s_q;
            s_q.valid <= 1'b0;
        end else if (accept && (!m_q.valid || pop)) begin
            m_q <= new_entry;
        end else if (accept) begin
            s_q <= new_entry;
        end else if (pop) begin
            m_q.valid <= 1'b0;
        end
    end

endmodule
